// File: rtl/mem_dcache_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_dcache_if
// Brief    : MEM-stage to DCache request/response channel.
// Revision : 1.0
// ============================================================================
interface mem_dcache_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wstrb, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_dcache_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_dcache_access
// Brief    : MEM-stage data-cache access: request issue, stall, load align.
// Revision : 1.0
// ============================================================================
module mem_dcache_access (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        mem_valid,
  input  wire logic        mem_flush,
  input  wire logic        wb_wr,
  input  wire logic        mem_except,
  input  wire logic        mem_ld_en,
  input  wire logic        mem_st_en,
  input  wire logic [1:0]  mem_size,
  input  wire logic        mem_ld_sign,
  input  wire logic [31:0] mem_addr,
  input  wire logic [31:0] mem_wdata,
  mem_dcache_if.master     dc,
  output logic             stall_req,
  output logic [31:0]      load_data,
  output logic             ex_adel,
  output logic             ex_ades
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_mis;
  logic        w_acc;
  logic        w_capture;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ld_ext;

  // Size 3 is treated as a word, so size[1] alone selects the word check.
  assign w_mis = ((mem_size == 2'd1) && mem_addr[0]) ||
                 (mem_size[1] && (mem_addr[1:0] != 2'b00));

  assign w_acc = mem_valid & (mem_ld_en | mem_st_en) & ~mem_except & ~w_mis & ~mem_flush;

  assign ex_adel = mem_valid & mem_ld_en & w_mis & ~mem_except;
  assign ex_ades = mem_valid & mem_st_en & w_mis & ~mem_except;

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = mem_wdata;
    case (mem_size)
      2'd0: begin
        w_wstrb = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        w_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
        w_wdata = {2{mem_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = mem_wdata;
      end
    endcase
    if (!mem_st_en) begin
      w_wstrb = 4'b0000;
    end
  end

  assign dc.req_wr    = mem_st_en;
  assign dc.req_addr  = mem_addr;
  assign dc.req_wstrb = w_wstrb;
  assign dc.req_wdata = w_wdata;

  assign w_shifted = dc.rsp_rdata >> {mem_addr[1:0], 3'b000};

  always_comb begin
    w_ld_ext = w_shifted;
    case (mem_size)
      2'd0:    w_ld_ext = {{24{mem_ld_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ld_ext = {{16{mem_ld_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ld_ext = w_shifted;
    endcase
  end

  assign w_capture = (r_state == S_RESP) & dc.rsp_valid & ~mem_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      load_data <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        load_data <= w_ld_ext;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    dc.req_valid = 1'b0;
    stall_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        dc.req_valid = w_acc;
        stall_req    = w_acc;
        if (w_acc) begin
          w_next = dc.req_ready ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        dc.req_valid = 1'b1;
        stall_req    = 1'b1;
        if (mem_flush) begin
          w_next = S_IDLE;
        end else if (dc.req_ready) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        stall_req = ~dc.rsp_valid;
        if (mem_flush) begin
          w_next = dc.rsp_valid ? S_IDLE : S_DRAIN;
        end else if (dc.rsp_valid) begin
          w_next = S_DONE;
        end
      end
      // Holding here keeps a completed instruction from re-issuing until WB takes it.
      S_DONE: begin
        if (wb_wr || mem_flush) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (dc.rsp_valid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dcache_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dcache_access
// Brief    : Directed self-checking bench for mem_dcache_access.
// Revision : 1.0
// ============================================================================
module tb_mem_dcache_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_flush, wb_wr, mem_except;
  logic        mem_ld_en, mem_st_en, mem_ld_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall_req, ex_adel, ex_ades;
  logic [31:0] load_data;

  int total  = 0;
  int passed = 0;

  mem_dcache_if dc_if ();

  mem_dcache_access dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_valid   (mem_valid),
    .mem_flush   (mem_flush),
    .wb_wr       (wb_wr),
    .mem_except  (mem_except),
    .mem_ld_en   (mem_ld_en),
    .mem_st_en   (mem_st_en),
    .mem_size    (mem_size),
    .mem_ld_sign (mem_ld_sign),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .dc          (dc_if),
    .stall_req   (stall_req),
    .load_data   (load_data),
    .ex_adel     (ex_adel),
    .ex_ades     (ex_ades)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    mem_valid   = v;
    mem_ld_en   = ld;
    mem_st_en   = st;
    mem_size    = sz;
    mem_ld_sign = sg;
    mem_addr    = a;
    mem_wdata   = wd;
  endtask

  // Minimum-latency load: accept at N, response at N+1, data in DONE at N+2.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] rd, input logic [31:0] exp);
    set_op(1'b1, 1'b1, 1'b0, sz, sg, a, 32'd0);
    dc_if.req_ready = 1'b1;
    #1;
    check({tag, "_req_valid"}, {31'd0, dc_if.req_valid}, 32'd1);
    check({tag, "_wstrb"}, {28'd0, dc_if.req_wstrb}, 32'd0);
    check({tag, "_stall_n"}, {31'd0, stall_req}, 32'd1);
    tick();
    dc_if.req_ready = 1'b0;
    dc_if.rsp_valid = 1'b1;
    dc_if.rsp_rdata = rd;
    #1;
    check({tag, "_stall_n1"}, {31'd0, stall_req}, 32'd0);
    tick();
    dc_if.rsp_valid = 1'b0;
    #1;
    check({tag, "_load_data"}, load_data, exp);
    check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    wb_wr = 1'b1;
    tick();
    wb_wr = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_flush = 1'b0; wb_wr = 1'b0; mem_except = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    dc_if.req_ready = 1'b0;
    dc_if.rsp_valid = 1'b0;
    dc_if.rsp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'd0, dc_if.req_valid}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Loads at minimum latency with several extraction cases
    do_load("lb_1003", 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lh_0100", 32'h0000_0100, 2'd1, 1'b1, 32'h0000_8001, 32'hFFFF_8001);
    do_load("lbu_0102", 32'h0000_0102, 2'd0, 1'b0, 32'h00AB_0000, 32'h0000_00AB);

    // SH with ready low for 3 cycles
    set_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
    dc_if.req_ready = 1'b0;
    #1;
    check("sh_valid0", {31'd0, dc_if.req_valid}, 32'd1);
    check("sh_wr", {31'd0, dc_if.req_wr}, 32'd1);
    check("sh_wstrb", {28'd0, dc_if.req_wstrb}, 32'h0000_000C);
    check("sh_wdata", dc_if.req_wdata, 32'hABCD_ABCD);
    check("sh_stall0", {31'd0, stall_req}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("sh_valid_held", {31'd0, dc_if.req_valid}, 32'd1);
      check("sh_stall_held", {31'd0, stall_req}, 32'd1);
    end
    tick();
    dc_if.req_ready = 1'b1;
    #1;
    check("sh_valid3", {31'd0, dc_if.req_valid}, 32'd1);
    tick();
    dc_if.req_ready = 1'b0;
    #1;
    check("sh_resp_valid", {31'd0, dc_if.req_valid}, 32'd0);
    check("sh_resp_stall", {31'd0, stall_req}, 32'd1);
    tick();
    dc_if.rsp_valid = 1'b1;
    dc_if.rsp_rdata = 32'd0;
    #1;
    check("sh_ack_stall", {31'd0, stall_req}, 32'd0);
    tick();
    dc_if.rsp_valid = 1'b0;
    wb_wr = 1'b1;
    #1;
    check("sh_done_stall", {31'd0, stall_req}, 32'd0);
    tick();
    wb_wr = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // Misalignment, exception suppression, and odd-address byte store
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0);
    dc_if.req_ready = 1'b1;
    #1;
    check("lw_mis_adel", {31'd0, ex_adel}, 32'd1);
    check("lw_mis_ades", {31'd0, ex_ades}, 32'd0);
    check("lw_mis_valid", {31'd0, dc_if.req_valid}, 32'd0);
    check("lw_mis_stall", {31'd0, stall_req}, 32'd0);
    tick();
    check("lw_mis_valid_next", {31'd0, dc_if.req_valid}, 32'd0);
    set_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_3003, 32'd0);
    #1;
    check("sh_mis_ades", {31'd0, ex_ades}, 32'd1);
    mem_except = 1'b1;
    #1;
    check("sh_mis_except_ades", {31'd0, ex_ades}, 32'd0);
    check("sh_mis_except_valid", {31'd0, dc_if.req_valid}, 32'd0);
    mem_except = 1'b0;
    dc_if.req_ready = 1'b0;
    set_op(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_7001, 32'h0000_005A);
    #1;
    check("sb_ades", {31'd0, ex_ades}, 32'd0);
    check("sb_valid", {31'd0, dc_if.req_valid}, 32'd1);
    check("sb_wstrb", {28'd0, dc_if.req_wstrb}, 32'h0000_0002);
    check("sb_wdata", dc_if.req_wdata, 32'h5A5A_5A5A);
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("sb_withdrawn", {31'd0, dc_if.req_valid}, 32'd0);
    tick();

    // LW completes; WB held off for 3 cycles
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0);
    dc_if.req_ready = 1'b1;
    #1;
    check("lw_hold_valid", {31'd0, dc_if.req_valid}, 32'd1);
    tick();
    dc_if.req_ready = 1'b0;
    dc_if.rsp_valid = 1'b1;
    dc_if.rsp_rdata = 32'hCAFE_F00D;
    tick();
    dc_if.rsp_valid = 1'b0;
    dc_if.req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_hold_data", load_data, 32'hCAFE_F00D);
      check("lw_hold_no_req", {31'd0, dc_if.req_valid}, 32'd0);
      check("lw_hold_stall", {31'd0, stall_req}, 32'd0);
      tick();
    end
    dc_if.req_ready = 1'b0;
    wb_wr = 1'b1;
    tick();
    wb_wr = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // LHU flushed in RESP, response lands 2 cycles later while draining
    set_op(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_4000, 32'd0);
    dc_if.req_ready = 1'b1;
    #1;
    check("drain_req_valid", {31'd0, dc_if.req_valid}, 32'd1);
    tick();
    dc_if.req_ready = 1'b0;
    mem_flush = 1'b1;
    #1;
    check("drain_flush_stall", {31'd0, stall_req}, 32'd1);
    tick();
    mem_flush = 1'b0;
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0);
    dc_if.req_ready = 1'b1;
    #1;
    check("drain_no_issue", {31'd0, dc_if.req_valid}, 32'd0);
    check("drain_stall", {31'd0, stall_req}, 32'd1);
    tick();
    dc_if.rsp_valid = 1'b1;
    dc_if.rsp_rdata = 32'hDEAD_BEEF;
    #1;
    check("drain_rsp_no_issue", {31'd0, dc_if.req_valid}, 32'd0);
    check("drain_rsp_stall", {31'd0, stall_req}, 32'd1);
    tick();
    dc_if.rsp_valid = 1'b0;
    #1;
    check("drain_reissue_valid", {31'd0, dc_if.req_valid}, 32'd1);
    check("drain_reissue_addr", dc_if.req_addr, 32'h0000_5000);
    check("drain_data_discarded", load_data, 32'hCAFE_F00D);
    tick();
    dc_if.req_ready = 1'b0;
    dc_if.rsp_valid = 1'b1;
    dc_if.rsp_rdata = 32'h1122_3344;
    #1;
    check("drain_lw_stall", {31'd0, stall_req}, 32'd0);
    tick();
    dc_if.rsp_valid = 1'b0;
    #1;
    check("drain_lw_data", load_data, 32'h1122_3344);
    wb_wr = 1'b1;
    tick();
    wb_wr = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // Reset asserted while waiting in REQ
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
    dc_if.req_ready = 1'b0;
    tick();
    check("rreq_valid", {31'd0, dc_if.req_valid}, 32'd1);
    check("rreq_stall", {31'd0, stall_req}, 32'd1);
    rst_n = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("rreq_async_valid", {31'd0, dc_if.req_valid}, 32'd0);
    check("rreq_async_stall", {31'd0, stall_req}, 32'd0);
    check("rreq_async_data", load_data, 32'd0);
    tick();
    check("rreq_hold_stall", {31'd0, stall_req}, 32'd0);
    rst_n = 1'b1;
    tick();
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_9000, 32'd0);
    #1;
    check("rreq_idle_valid", {31'd0, dc_if.req_valid}, 32'd1);
    tick();
    check("rreq_to_req_stall", {31'd0, stall_req}, 32'd1);
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("flush_req_idle", {31'd0, stall_req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
